// File: rtl/pcileech_eth_pkg.sv
// Shared types and constants for the RMII Ethernet transmit/receive paths.
package pcileech_eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DRAIN
    } eth_tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/pcileech_eth_crc32.sv
// Byte-wide Ethernet CRC32 step (reflected), combinational; shared by TX FCS
// generation and RX FCS checking.
module pcileech_eth_crc32
    import pcileech_eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    always_comb begin
        o_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            o_crc = (o_crc[0] ^ i_data[i]) ? ((o_crc >> 1) ^ ETH_CRC_POLY) : (o_crc >> 1);
        end
    end

endmodule

// File: rtl/pcileech_eth_rmii_tx.sv
// RMII MAC transmitter: preamble, SFD, payload, optional zero pad, FCS and IFG,
// 2 bits per 50 MHz clock. Zero padding is built when PCILEECH_ETH_TX_PAD_EN is defined.
module pcileech_eth_rmii_tx
    import pcileech_eth_pkg::*;
#(
    parameter int PARAM_IFG_BYTES   = 12,
    parameter int PARAM_MIN_PAYLOAD = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        eth_tx_en,
    output logic [1:0]  eth_tx_data,
    output logic        busy,
    output logic        err_underrun,
    output logic [15:0] tx_frames
);

`ifdef PCILEECH_ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam logic [10:0] BCNT_MAX = 11'd2047;
    localparam logic [10:0] MIN_PAY  = 11'(PARAM_MIN_PAYLOAD);
    localparam logic [10:0] IFG_LAST = 11'(PARAM_IFG_BYTES - 1);

    eth_tx_state_t r_state, w_state_nxt;
    logic [1:0]    r_dcnt, w_dcnt_nxt;
    logic [10:0]   r_bcnt, w_bcnt_nxt, w_bcnt_inc;
    logic [7:0]    r_shift, w_shift_nxt, w_crc_byte;
    logic [31:0]   r_crc, w_crc_nxt, w_crc_upd;
    logic          r_last, w_last_nxt;
    logic          r_in_ready, r_tx_en, r_busy, r_underrun;
    logic [1:0]    r_txd;
    logic [15:0]   r_tx_frames;
    logic          w_take, w_underrun, w_byte_end, w_to_fcs, w_frame_done;
    logic          w_en_nxt, w_ready_nxt;
    logic [1:0]    w_txd_nxt;

    pcileech_eth_crc32 u_crc (
        .i_crc  (r_crc),
        .i_data (w_crc_byte),
        .o_crc  (w_crc_upd)
    );

    always_comb begin
        w_take       = in_valid & r_in_ready;
        w_underrun   = r_in_ready & ~in_valid & (r_state != ST_DRAIN);
        w_byte_end   = (r_dcnt == 2'd3);
        w_bcnt_inc   = (r_bcnt == BCNT_MAX) ? r_bcnt : r_bcnt + 11'd1;
        w_crc_byte   = w_take ? in_data : 8'h00;
        w_state_nxt  = r_state;
        w_dcnt_nxt   = 2'(r_dcnt + 2'd1);
        w_bcnt_nxt   = r_bcnt;
        w_shift_nxt  = r_shift;
        w_crc_nxt    = r_crc;
        w_last_nxt   = r_last;
        w_to_fcs     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_dcnt_nxt = 2'd0;
                if (in_valid) begin
                    w_state_nxt = ST_PRE;
                    w_bcnt_nxt  = 11'd0;
                    w_shift_nxt = ETH_PREAMBLE;
                    w_crc_nxt   = ETH_CRC_INIT;
                    w_last_nxt  = 1'b0;
                end
            end
            ST_PRE: begin
                w_crc_nxt = ETH_CRC_INIT;
                if (w_byte_end) begin
                    if (r_bcnt == 11'd6) begin
                        w_state_nxt = ST_SFD;
                        w_shift_nxt = ETH_SFD;
                        w_bcnt_nxt  = 11'd0;
                    end else begin
                        w_bcnt_nxt = r_bcnt + 11'd1;
                    end
                end
            end
            ST_SFD, ST_DATA: begin
                if (w_byte_end) begin
                    if (w_take) begin
                        w_state_nxt = ST_DATA;
                        w_shift_nxt = in_data;
                        w_crc_nxt   = w_crc_upd;
                        w_bcnt_nxt  = w_bcnt_inc;
                        w_last_nxt  = in_last;
                    end else if (w_underrun) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (PAD_EN && (r_bcnt < MIN_PAY)) begin
                        w_state_nxt = ST_PAD;
                        w_shift_nxt = 8'h00;
                        w_crc_nxt   = w_crc_upd;
                        w_bcnt_nxt  = w_bcnt_inc;
                    end else begin
                        w_to_fcs = 1'b1;
                    end
                end
            end
`ifdef PCILEECH_ETH_TX_PAD_EN
            ST_PAD: begin
                if (w_byte_end) begin
                    if (r_bcnt == MIN_PAY) begin
                        w_to_fcs = 1'b1;
                    end else begin
                        w_crc_nxt  = w_crc_upd;
                        w_bcnt_nxt = w_bcnt_inc;
                    end
                end
            end
`endif
            ST_FCS: begin
                if (w_byte_end) begin
                    if (r_bcnt == 11'd3) begin
                        w_state_nxt  = ST_IFG;
                        w_bcnt_nxt   = 11'd0;
                        w_frame_done = 1'b1;
                    end else begin
                        w_shift_nxt = ~r_crc[7:0];
                        w_crc_nxt   = r_crc >> 8;
                        w_bcnt_nxt  = r_bcnt + 11'd1;
                    end
                end
            end
            ST_IFG: begin
                // Leave one cycle early: the IDLE cycle completes the gap.
                if (r_dcnt == 2'd2 && r_bcnt == IFG_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_byte_end) begin
                    w_bcnt_nxt = r_bcnt + 11'd1;
                end
            end
            ST_DRAIN: begin
                w_dcnt_nxt = 2'd0;
                if (w_take && in_last) begin
                    w_state_nxt = ST_IFG;
                    w_bcnt_nxt  = 11'd0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // FCS goes out inverted, low byte first; r_crc shifts down a byte each time.
        if (w_to_fcs) begin
            w_state_nxt = ST_FCS;
            w_shift_nxt = ~r_crc[7:0];
            w_crc_nxt   = r_crc >> 8;
            w_bcnt_nxt  = 11'd0;
        end
        w_en_nxt    = (w_state_nxt == ST_PRE) || (w_state_nxt == ST_SFD) || (w_state_nxt == ST_DATA) ||
                      (w_state_nxt == ST_PAD) || (w_state_nxt == ST_FCS);
        w_txd_nxt   = w_en_nxt ? 2'(w_shift_nxt >> {w_dcnt_nxt, 1'b0}) : 2'b00;
        w_ready_nxt = (w_state_nxt == ST_DRAIN) ||
                      ((w_dcnt_nxt == 2'd3) && ((w_state_nxt == ST_SFD) ||
                                                 ((w_state_nxt == ST_DATA) && !w_last_nxt)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dcnt      <= 2'd0;
            r_bcnt      <= 11'd0;
            r_shift     <= 8'h00;
            r_crc       <= ETH_CRC_INIT;
            r_last      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_tx_en     <= 1'b0;
            r_txd       <= 2'b00;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
            r_tx_frames <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_shift    <= w_shift_nxt;
            r_crc      <= w_crc_nxt;
            r_last     <= w_last_nxt;
            r_in_ready <= w_ready_nxt;
            r_tx_en    <= w_en_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_underrun <= w_underrun;
            if (w_frame_done) begin
                r_tx_frames <= r_tx_frames + 16'd1;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign eth_tx_en    = r_tx_en;
    assign eth_tx_data  = r_txd;
    assign busy         = r_busy;
    assign err_underrun = r_underrun;
    assign tx_frames    = r_tx_frames;

endmodule

// File: tb/tb_pcileech_eth_rmii_tx.sv
// Scoreboard bench for pcileech_eth_rmii_tx; expectations follow PCILEECH_ETH_TX_PAD_EN.
module tb_pcileech_eth_rmii_tx;

    localparam int MIN_PAY = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready, eth_tx_en, busy, err_underrun;
    logic [1:0]  eth_tx_data;
    logic [15:0] tx_frames;

    always #10 clk = ~clk;

    pcileech_eth_rmii_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .eth_tx_en    (eth_tx_en),
        .eth_tx_data  (eth_tx_data),
        .busy         (busy),
        .err_underrun (err_underrun),
        .tx_frames    (tx_frames)
    );

    int          n_chk = 0, n_err = 0;
    logic [7:0]  q_exp[$];
    int          q_len[$];
    logic [7:0]  tx_buf[$];
    bit          mon_on = 1'b0;
    bit          prev_en = 1'b0;
    int          acc_n = 0, run = 0, gap = 0, last_gap = 0, n_underrun = 0;
    logic [7:0]  acc = 8'h00;
    logic [31:0] last4 = 32'h0, frame_fcs = 32'h0;
    logic [15:0] exp_frames = 16'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Expected wire bytes and TX_EN length for the frame in tx_buf.
    task automatic push_frame(input int drop_at);
        logic [31:0] c, f;
        int          sent, total;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) q_exp.push_back(8'h55);
        q_exp.push_back(8'hD5);
        sent = (drop_at >= 0) ? drop_at : tx_buf.size();
        for (int i = 0; i < sent; i++) begin
            q_exp.push_back(tx_buf[i]);
            c = crc_upd(c, tx_buf[i]);
        end
        total = 8 + sent;
        if (drop_at < 0) begin
`ifdef PCILEECH_ETH_TX_PAD_EN
            for (int i = tx_buf.size(); i < MIN_PAY; i++) begin
                q_exp.push_back(8'h00);
                c = crc_upd(c, 8'h00);
                total++;
            end
`endif
            f = ~c;
            for (int k = 0; k < 4; k++) begin
                q_exp.push_back(f[7:0]);
                f = f >> 8;
            end
            total += 4;
        end
        q_len.push_back(4 * total);
    endtask

    task automatic wait_accept(input string tag);
        bit ok;
        int t;
        t = 0;
        do begin
            @(negedge clk);
            ok = in_ready && in_valid;
            @(posedge clk);
            t++;
        end while (!ok && t < 2000);
        chk(tag, ok, 1);
        #1;
    endtask

    task automatic send_frame(input int drop_at, input bit push);
        int t;
        if (push) push_frame(drop_at);
        for (int i = 0; i < tx_buf.size(); i++) begin
            if (i == drop_at) begin
                in_valid = 1'b0;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!in_ready && t < 500);
                chk("due_seen", in_ready, 1);
                @(posedge clk);
                #1;
                @(negedge clk);
                chk("drain_ready", in_ready, 1);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = tx_buf[i];
            in_last  = (i == tx_buf.size() - 1);
            wait_accept("accept");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 5000);
        chk("idle", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!mon_on) begin
            acc_n   = 0;
            run     = 0;
            prev_en = 1'b0;
        end else begin
            if (eth_tx_en) begin
                if (!prev_en) begin
                    last_gap = gap;
                    gap      = 0;
                end
                acc = {eth_tx_data, acc[7:2]};
                acc_n++;
                run++;
                if (acc_n == 4) begin
                    acc_n = 0;
                    last4 = {acc, last4[31:8]};
                    if (q_exp.size() == 0) chk("byte_unexpected", acc, 8'hXX);
                    else chk("byte", acc, q_exp.pop_front());
                end
            end else begin
                if (prev_en) begin
                    if (q_len.size() == 0) chk("frame_unexpected", run, 0);
                    else chk("frame_len", run, q_len.pop_front());
                    chk("frame_align", acc_n, 0);
                    frame_fcs = last4;
                    run   = 0;
                    acc_n = 0;
                end
                gap++;
            end
            if (err_underrun) begin
                n_underrun++;
                chk("en_at_underrun", eth_tx_en, 0);
            end
            prev_en = eth_tx_en;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", eth_tx_en, 0);
        chk("rst_txd", eth_tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_underrun", err_underrun, 0);
        chk("rst_frames", tx_frames, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_on = 1'b1;

        // 1: "123456789"
        tx_buf = {};
        for (int i = 0; i < 9; i++) tx_buf.push_back(8'(8'h31 + i));
        send_frame(-1, 1);
        exp_frames++;
        wait_idle();
        chk("t1_frames", tx_frames, exp_frames);
`ifndef PCILEECH_ETH_TX_PAD_EN
        chk("t1_fcs", frame_fcs, 32'hCBF43926);
`endif

        // 2: single byte frame (padded when pad is built)
        tx_buf = {8'hAB};
        send_frame(-1, 1);
        exp_frames++;
        wait_idle();
        chk("t2_frames", tx_frames, exp_frames);

        // 3: back-to-back frames, in_valid held high
        tx_buf = {};
        for (int i = 0; i < 64; i++) tx_buf.push_back(8'($urandom_range(0, 255)));
        send_frame(-1, 1);
        tx_buf = {};
        for (int i = 0; i < 10; i++) tx_buf.push_back(8'($urandom_range(0, 255)));
        send_frame(-1, 1);
        exp_frames += 16'd2;
        wait_idle();
        chk("t3_gap", last_gap, 48);
        chk("t3_frames", tx_frames, exp_frames);

        // 4: underrun at the fifth payload byte of 20
        n_underrun = 0;
        tx_buf = {};
        for (int i = 0; i < 20; i++) tx_buf.push_back(8'(8'hA0 + i));
        send_frame(4, 1);
        wait_idle();
        chk("t4_pulses", n_underrun, 1);
        chk("t4_frames", tx_frames, exp_frames);

        // 5: reset during the tail of a frame
        mon_on = 1'b0;
        tx_buf = {};
        for (int i = 0; i < 8; i++) tx_buf.push_back(8'(8'h10 + i));
        send_frame(-1, 0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_en_before", eth_tx_en, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_en", eth_tx_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_frames", tx_frames, 0);
        exp_frames = 16'h0;
        mon_on = 1'b1;
        tx_buf = {};
        for (int i = 0; i < 12; i++) tx_buf.push_back(8'($urandom_range(0, 255)));
        send_frame(-1, 1);
        exp_frames++;
        wait_idle();
        chk("t5_after", tx_frames, exp_frames);

        // 6: counter wrap from a preloaded 0xFFFF
        @(negedge clk);
        force dut.r_tx_frames = 16'hFFFF;
        @(negedge clk);
        release dut.r_tx_frames;
        exp_frames = 16'hFFFF;
        tx_buf = {8'h5A};
        send_frame(-1, 1);
        exp_frames++;
        wait_idle();
        chk("t6_wrap", tx_frames, exp_frames);

        repeat (4) @(negedge clk);
        chk("sb_empty", q_exp.size() + q_len.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
